// File: rtl/cpu_pkg.sv
// Shared types for the fetch-control slice: FSM states, redirect priority
// encoding and the default address width / reset vector.
package cpu_pkg;

    localparam int          XLEN_DEFAULT      = 32;
    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

    // Sequencer states; anything other than ST_RUN reports busy.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PEND  = 2'd2,
        ST_STALL = 2'd3
    } fsm_state_t;

    // Redirect priority: the numerically larger source always wins.
    typedef enum logic [1:0] {
        PRIO_NONE = 2'd0,
        PRIO_JMP  = 2'd1,
        PRIO_BR   = 2'd2,
        PRIO_TRAP = 2'd3
    } prio_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle between the fetch sequencer and the pipeline around it: redirect
// sources, hazard/memory status in, PC-register controls and kills out.
//
// Handshake: a redirect source is valid while its request bit (trap_req,
// br_taken, jmp_req) is high, and imem_ready is the memory-side ready. A
// redirect is consumed (PCS=1) only in a cycle where imem_ready=1; otherwise
// the sequencer parks it and holds the PC until ready returns. Sources must
// hold or re-present their request until it is consumed or superseded.
interface fetch_ctrl_if #(
    parameter int XLEN = cpu_pkg::XLEN_DEFAULT
);
    import cpu_pkg::*;

    logic            trap_req;
    logic [XLEN-1:0] trap_vec;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            jmp_req;
    logic [XLEN-1:0] jmp_target;
    logic            lu_hazard;
    logic            imem_ready;

    logic            PCS;
    logic [XLEN-1:0] JADDR;
    logic            Flush;
    logic            FlushBack;
    logic            ifid_kill;
    logic            idex_kill;
    logic            busy;
    fsm_state_t      state;      // debug view of the sequencer state

    modport slave (
        input  trap_req, trap_vec, br_taken, br_target, jmp_req, jmp_target,
               lu_hazard, imem_ready,
        output PCS, JADDR, Flush, FlushBack, ifid_kill, idex_kill, busy, state
    );

    modport master (
        output trap_req, trap_vec, br_taken, br_target, jmp_req, jmp_target,
               lu_hazard, imem_ready,
        input  PCS, JADDR, Flush, FlushBack, ifid_kill, idex_kill, busy, state
    );

endinterface

// File: rtl/redirect_arb.sv
// Fixed-priority redirect select: trap > branch > jump. Also reports the
// pipeline kills the winning source needs.
module redirect_arb
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jmp_req,
    input  logic [XLEN-1:0] jmp_target,
    output logic            valid,
    output prio_t           prio,
    output logic [XLEN-1:0] target,
    output logic            kill_ifid,
    output logic            kill_idex
);

    // Pick the oldest requesting instruction; a jump in ID only needs IF/ID killed.
    always_comb begin
        valid  = 1'b0;
        prio   = PRIO_NONE;
        target = '0;
        if (trap_req) begin
            valid  = 1'b1;
            prio   = PRIO_TRAP;
            target = trap_vec;
        end else if (br_taken) begin
            valid  = 1'b1;
            prio   = PRIO_BR;
            target = br_target;
        end else if (jmp_req) begin
            valid  = 1'b1;
            prio   = PRIO_JMP;
            target = jmp_target;
        end
        kill_ifid = valid;
        kill_idex = (prio == PRIO_TRAP) || (prio == PRIO_BR);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch PC sequencer: boot fetch, redirect arbitration, parking of
// redirects across imem wait states, and load-use stall/replay.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VEC    = XLEN'(RESET_VEC_DEFAULT),
    parameter int              STALL_CYCLES = 1
) (
    input logic         CLK,
    input logic         rst,
    fetch_ctrl_if.slave bus
);

    fsm_state_t      state_q, state_nxt;
    logic [XLEN-1:0] pend_addr_q, pend_addr_nxt;
    prio_t           pend_prio_q, pend_prio_nxt;
    logic [2:0]      stall_cnt_q, stall_cnt_nxt;

    logic            arb_valid;
    prio_t           arb_prio;
    logic [XLEN-1:0] arb_target;
    logic            arb_kill_ifid;
    logic            arb_kill_idex;
    logic            upgrade;

    logic            pcs, flush, flush_back, ifid_kill, idex_kill;
    logic [XLEN-1:0] jaddr;

    redirect_arb #(.XLEN(XLEN)) u_arb (
        .trap_req   (bus.trap_req),
        .trap_vec   (bus.trap_vec),
        .br_taken   (bus.br_taken),
        .br_target  (bus.br_target),
        .jmp_req    (bus.jmp_req),
        .jmp_target (bus.jmp_target),
        .valid      (arb_valid),
        .prio       (arb_prio),
        .target     (arb_target),
        .kill_ifid  (arb_kill_ifid),
        .kill_idex  (arb_kill_idex)
    );

    // A new request may only displace a parked redirect from an older instruction.
    assign upgrade = arb_valid && (arb_prio > pend_prio_q);

    // State, parked redirect and stall counter; reset restarts from the boot fetch.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pend_addr_q <= '0;
            pend_prio_q <= PRIO_NONE;
            stall_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_nxt;
            pend_addr_q <= pend_addr_nxt;
            pend_prio_q <= pend_prio_nxt;
            stall_cnt_q <= stall_cnt_nxt;
        end
    end

    // Next state and PC controls; PCS is only ever raised alone of Flush/FlushBack.
    always_comb begin
        state_nxt     = state_q;
        pend_addr_nxt = pend_addr_q;
        pend_prio_nxt = pend_prio_q;
        stall_cnt_nxt = stall_cnt_q;
        pcs           = 1'b0;
        jaddr         = '0;
        flush         = 1'b0;
        flush_back    = 1'b0;
        ifid_kill     = 1'b0;
        idex_kill     = 1'b0;

        case (state_q)
            ST_BOOT: begin
                pcs       = 1'b1;
                jaddr     = RESET_VEC;
                ifid_kill = 1'b1;
                idex_kill = 1'b1;
                state_nxt = ST_RUN;
            end

            ST_RUN, ST_STALL: begin
                if (arb_valid) begin
                    // A redirect beats a hazard and aborts any stall in progress.
                    ifid_kill     = arb_kill_ifid;
                    idex_kill     = arb_kill_idex;
                    stall_cnt_nxt = 3'd0;
                    if (bus.imem_ready) begin
                        pcs       = 1'b1;
                        jaddr     = arb_target;
                        state_nxt = ST_RUN;
                    end else begin
                        flush         = 1'b1;
                        pend_addr_nxt = arb_target;
                        pend_prio_nxt = arb_prio;
                        state_nxt     = ST_PEND;
                    end
                end else if (state_q == ST_RUN) begin
                    if (bus.lu_hazard) begin
                        flush         = 1'b1;
                        idex_kill     = 1'b1;
                        stall_cnt_nxt = 3'(STALL_CYCLES);
                        state_nxt     = ST_STALL;
                    end else if (!bus.imem_ready) begin
                        flush = 1'b1;
                    end
                end else begin
                    idex_kill = 1'b1;
                    if (stall_cnt_q > 3'd1) begin
                        flush         = 1'b1;
                        stall_cnt_nxt = stall_cnt_q - 3'd1;
                    end else begin
                        // Last stall cycle: replay the fetch that was overwritten.
                        flush_back = 1'b1;
                        if (bus.imem_ready) begin
                            stall_cnt_nxt = 3'd0;
                            state_nxt     = ST_RUN;
                        end
                    end
                end
            end

            ST_PEND: begin
                if (upgrade) begin
                    ifid_kill     = arb_kill_ifid;
                    idex_kill     = arb_kill_idex;
                    pend_addr_nxt = arb_target;
                    pend_prio_nxt = arb_prio;
                end
                if (bus.imem_ready) begin
                    pcs           = 1'b1;
                    jaddr         = upgrade ? arb_target : pend_addr_q;
                    pend_prio_nxt = PRIO_NONE;
                    state_nxt     = ST_RUN;
                end else begin
                    flush = 1'b1;
                end
            end

            default: state_nxt = ST_BOOT;
        endcase
    end

    // Reset forces every control low immediately, independent of the clock.
    assign bus.PCS       = !rst && pcs;
    assign bus.JADDR     = rst ? '0 : jaddr;
    assign bus.Flush     = !rst && flush;
    assign bus.FlushBack = !rst && flush_back;
    assign bus.ifid_kill = !rst && ifid_kill;
    assign bus.idex_kill = !rst && idex_kill;
    assign bus.busy      = !rst && (state_q != ST_RUN);
    assign bus.state     = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, random traffic against a
// behavioural model, and an asynchronous reset taken in the middle of a PEND.
module tb_fetch_ctrl;
    import cpu_pkg::*;

    localparam int          XLEN    = 32;
    localparam logic [31:0] RST_VEC = 32'h0000_0000;
    localparam int          STALL_N = 2;

    typedef struct packed {
        logic        trap;
        logic [31:0] trap_vec;
        logic        br;
        logic [31:0] br_tgt;
        logic        jmp;
        logic [31:0] jmp_tgt;
        logic        lu;
        logic        ready;
    } stim_t;

    typedef struct packed {
        logic        pcs;
        logic [31:0] jaddr;
        logic        flush;
        logic        flush_back;
        logic        ifid_kill;
        logic        idex_kill;
        logic        busy;
    } outs_t;

    typedef struct {
        stim_t      s;
        outs_t      e;
        fsm_state_t st;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic CLK;
    logic rst;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    fetch_ctrl_if #(.XLEN(XLEN)) bus ();

    fetch_ctrl #(
        .XLEN         (XLEN),
        .RESET_VEC    (RST_VEC),
        .STALL_CYCLES (STALL_N)
    ) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    int          n_pass  = 0;
    int          n_total = 0;
    logic [37:0] exp_q[$];

    // Behavioural model: what the fetch sequencer is doing, in plain terms.
    bit          m_boot;
    bit          m_pend;
    int          m_pend_prio;
    logic [31:0] m_pend_addr;
    int          m_stall;       // stall cycles still to serve, 0 when not stalling

    task automatic check(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h, want %h", name, id, act, exp);
    endtask

    function automatic stim_t mk(bit trap, logic [31:0] tv, bit br, logic [31:0] bt,
                                 bit jmp, logic [31:0] jt, bit lu, bit rdy);
        stim_t s;
        s.trap = trap; s.trap_vec = tv; s.br = br; s.br_tgt = bt;
        s.jmp = jmp; s.jmp_tgt = jt; s.lu = lu; s.ready = rdy;
        return s;
    endfunction

    function automatic stim_t idle(bit rdy);
        return mk(0, 0, 0, 0, 0, 0, 0, rdy);
    endfunction

    function automatic outs_t mo(bit pcs, logic [31:0] ja, bit fl, bit fb, bit ik, bit xk, bit bz);
        outs_t o;
        o.pcs = pcs; o.jaddr = ja; o.flush = fl; o.flush_back = fb;
        o.ifid_kill = ik; o.idex_kill = xk; o.busy = bz;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.pcs        = bus.PCS;
        o.jaddr      = bus.JADDR;
        o.flush      = bus.Flush;
        o.flush_back = bus.FlushBack;
        o.ifid_kill  = bus.ifid_kill;
        o.idex_kill  = bus.idex_kill;
        o.busy       = bus.busy;
        return o;
    endfunction

    task automatic model_reset();
        m_boot      = 1'b1;
        m_pend      = 1'b0;
        m_pend_prio = 0;
        m_pend_addr = '0;
        m_stall     = 0;
    endtask

    // One clock of the model: expected controls for this cycle, then advance.
    task automatic model_step(input stim_t s, output outs_t e, output fsm_state_t est);
        int          p;
        logic [31:0] t;
        e = '0;
        if (s.trap)     begin p = 3; t = s.trap_vec; end
        else if (s.br)  begin p = 2; t = s.br_tgt;   end
        else if (s.jmp) begin p = 1; t = s.jmp_tgt;  end
        else            begin p = 0; t = '0;         end

        est = m_boot ? ST_BOOT : m_pend ? ST_PEND : (m_stall > 0) ? ST_STALL : ST_RUN;
        e.busy = (est != ST_RUN);

        if (m_boot) begin
            e.pcs = 1; e.jaddr = RST_VEC; e.ifid_kill = 1; e.idex_kill = 1;
            m_boot = 1'b0;
        end else if (m_pend) begin
            if (p > m_pend_prio) begin
                e.ifid_kill = 1; e.idex_kill = (p >= 2);
                m_pend_prio = p; m_pend_addr = t;
            end
            if (s.ready) begin
                e.pcs = 1; e.jaddr = m_pend_addr; m_pend = 1'b0;
            end else begin
                e.flush = 1;
            end
        end else if (p > 0) begin
            e.ifid_kill = 1; e.idex_kill = (p >= 2);
            m_stall = 0;
            if (s.ready) begin
                e.pcs = 1; e.jaddr = t;
            end else begin
                e.flush = 1;
                m_pend = 1'b1; m_pend_prio = p; m_pend_addr = t;
            end
        end else if (m_stall > 0) begin
            e.idex_kill = 1;
            if (m_stall > 1) begin
                e.flush = 1; m_stall--;
            end else begin
                e.flush_back = 1;
                if (s.ready) m_stall = 0;
            end
        end else if (s.lu) begin
            e.flush = 1; e.idex_kill = 1; m_stall = STALL_N;
        end else if (!s.ready) begin
            e.flush = 1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input stim_t s);
        bus.trap_req   = s.trap;
        bus.trap_vec   = s.trap_vec;
        bus.br_taken   = s.br;
        bus.br_target  = s.br_tgt;
        bus.jmp_req    = s.jmp;
        bus.jmp_target = s.jmp_tgt;
        bus.lu_hazard  = s.lu;
        bus.imem_ready = s.ready;
    endtask

    // Drive at the falling edge, check settled outputs before the next rising edge.
    task automatic step(input stim_t s, input bit use_tbl, input outs_t tbl_e,
                        input fsm_state_t tbl_st, input int id);
        outs_t      e;
        outs_t      act;
        fsm_state_t est;
        @(negedge CLK);
        drive(s);
        model_step(s, e, est);
        exp_q.push_back(e);
        #1;
        act = sample();
        check("model_outs", id, 64'(act), 64'(exp_q.pop_front()));
        check("model_state", id, 64'(bus.state), 64'(est));
        if (use_tbl) begin
            check("tbl_outs", id, 64'(act), 64'(tbl_e));
            check("tbl_state", id, 64'(bus.state), 64'(tbl_st));
        end
    endtask

    vec_t tbl[22];

    initial begin
        stim_t s;

        // Directed table from boot; STALL_CYCLES=2, RESET_VEC=0.
        tbl[0]  = '{idle(1), mo(1, 32'h0, 0, 0, 1, 1, 1), ST_BOOT};
        tbl[1]  = '{idle(1), mo(0, 32'h0, 0, 0, 0, 0, 0), ST_RUN};
        tbl[2]  = '{mk(0, 0, 1, 32'h200, 1, 32'h100, 0, 1), mo(1, 32'h200, 0, 0, 1, 1, 0), ST_RUN};
        tbl[3]  = '{mk(0, 0, 1, 32'h300, 0, 0, 0, 0), mo(0, 32'h0, 1, 0, 1, 1, 0), ST_RUN};
        tbl[4]  = '{mk(1, 32'h80, 0, 0, 0, 0, 0, 0), mo(0, 32'h0, 1, 0, 1, 1, 1), ST_PEND};
        tbl[5]  = '{mk(0, 0, 0, 0, 1, 32'h500, 0, 0), mo(0, 32'h0, 1, 0, 0, 0, 1), ST_PEND};
        tbl[6]  = '{idle(1), mo(1, 32'h80, 0, 0, 0, 0, 1), ST_PEND};
        tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 1, 1), mo(0, 32'h0, 1, 0, 0, 1, 0), ST_RUN};
        tbl[8]  = '{idle(1), mo(0, 32'h0, 1, 0, 0, 1, 1), ST_STALL};
        tbl[9]  = '{idle(1), mo(0, 32'h0, 0, 1, 0, 1, 1), ST_STALL};
        tbl[10] = '{idle(1), mo(0, 32'h0, 0, 0, 0, 0, 0), ST_RUN};
        tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 1, 1), mo(0, 32'h0, 1, 0, 0, 1, 0), ST_RUN};
        tbl[12] = '{mk(0, 0, 1, 32'h400, 0, 0, 0, 1), mo(1, 32'h400, 0, 0, 1, 1, 1), ST_STALL};
        tbl[13] = '{idle(1), mo(0, 32'h0, 0, 0, 0, 0, 0), ST_RUN};
        tbl[14] = '{mk(0, 0, 0, 0, 0, 0, 1, 1), mo(0, 32'h0, 1, 0, 0, 1, 0), ST_RUN};
        tbl[15] = '{idle(1), mo(0, 32'h0, 1, 0, 0, 1, 1), ST_STALL};
        tbl[16] = '{idle(0), mo(0, 32'h0, 0, 1, 0, 1, 1), ST_STALL};
        tbl[17] = '{idle(0), mo(0, 32'h0, 0, 1, 0, 1, 1), ST_STALL};
        tbl[18] = '{idle(1), mo(0, 32'h0, 0, 1, 0, 1, 1), ST_STALL};
        tbl[19] = '{idle(0), mo(0, 32'h0, 1, 0, 0, 0, 0), ST_RUN};
        tbl[20] = '{mk(0, 0, 0, 0, 1, 32'h600, 0, 1), mo(1, 32'h600, 0, 0, 1, 0, 0), ST_RUN};
        tbl[21] = '{mk(0, 0, 0, 0, 1, 32'h700, 1, 1), mo(1, 32'h700, 0, 0, 1, 0, 0), ST_RUN};

        // Power-on reset: everything low while rst is high.
        rst = 1'b1;
        drive(idle(1));
        model_reset();
        #1;
        check("reset_outs", 0, 64'(sample()), 64'(0));
        check("reset_state", 0, 64'(bus.state), 64'(ST_BOOT));
        repeat (2) @(posedge CLK);
        #2 rst = 1'b0;

        for (int i = 0; i < 22; i++) step(tbl[i].s, 1'b1, tbl[i].e, tbl[i].st, i);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            s.trap     = ($urandom_range(0, 15) == 0);
            s.trap_vec = $urandom & 32'hFFFF_FFFC;
            s.br       = ($urandom_range(0, 7) == 0);
            s.br_tgt   = $urandom & 32'hFFFF_FFFC;
            s.jmp      = ($urandom_range(0, 7) == 0);
            s.jmp_tgt  = $urandom & 32'hFFFF_FFFC;
            s.lu       = ($urandom_range(0, 5) == 0);
            s.ready    = ($urandom_range(0, 3) != 0);
            step(s, 1'b0, '0, ST_RUN, 100 + i);
        end

        // Drain back to RUN, then park a branch and reset in the middle of PEND.
        repeat (4) step(idle(1), 1'b0, '0, ST_RUN, 800);
        step(mk(0, 0, 1, 32'hDEAD_0000, 0, 0, 0, 0), 1'b0, '0, ST_RUN, 900);
        step(idle(0), 1'b1, mo(0, 32'h0, 1, 0, 0, 0, 1), ST_PEND, 901);
        @(negedge CLK);
        drive(idle(1));
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("async_reset_outs", 902, 64'(sample()), 64'(0));
        check("async_reset_state", 902, 64'(bus.state), 64'(ST_BOOT));
        @(posedge CLK);
        #2 rst = 1'b0;
        step(idle(1), 1'b1, mo(1, 32'h0, 0, 0, 1, 1, 1), ST_BOOT, 903);
        step(idle(1), 1'b1, mo(0, 32'h0, 0, 0, 0, 0, 0), ST_RUN, 904);
        step(idle(1), 1'b1, mo(0, 32'h0, 0, 0, 0, 0, 0), ST_RUN, 905);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
